// File: rtl/register_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : register_write_arbiter
// Description : Round-robin write arbiter for one shared WIDTH-bit holding
//               register. The granted requester writes its data slice every
//               cycle it keeps req high; a hold limit forces handoff when
//               other requesters are waiting.
// Revision    : 1.0 - initial release
// ============================================================================
module register_write_arbiter #(
  parameter int WIDTH    = 8,
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic                     busy,
  output logic [$clog2(NUM_REQ)-1:0] owner_id,
  output logic [WIDTH-1:0]         data_out,
  output logic                     data_valid
);

  localparam int IDW = $clog2(NUM_REQ);
  // hold counter needs at least one bit even when MAX_HOLD is 1
  localparam int HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] c_hold_last = HCW'(MAX_HOLD - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_OWN  = 1'b1
  } state_t;

  state_t             r_state;
  logic [HCW-1:0]     r_hold_cnt;
  logic [IDW-1:0]     r_owner_id;
  logic [NUM_REQ-1:0] r_gnt;
  logic               r_busy;
  logic [WIDTH-1:0]   r_data_out;
  logic               r_data_valid;

  logic [WIDTH-1:0]   w_slice [NUM_REQ];
  logic               w_other_found;
  logic [IDW-1:0]     w_other_idx;
  logic [IDW-1:0]     w_sel_idx;
  logic               w_owner_req;
  logic               w_at_limit;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Split the flat write bus into per-requester slices
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      w_slice[i] = wdata[i*WIDTH +: WIDTH];
    end
  end

  // Round-robin search over everyone except the current/last owner,
  // starting just after it; the owner itself is the lowest-priority fallback
  always_comb begin
    logic [IDW-1:0] idx;
    w_other_found = 1'b0;
    w_other_idx   = r_owner_id;
    idx           = r_owner_id;
    for (int k = 1; k < NUM_REQ; k++) begin
      idx = r_owner_id + IDW'(k);
      if (!w_other_found && req[idx]) begin
        w_other_found = 1'b1;
        w_other_idx   = idx;
      end
    end
    w_sel_idx   = w_other_found ? w_other_idx : r_owner_id;
    w_owner_req = req[r_owner_id];
    w_at_limit  = (r_hold_cnt == c_hold_last);
  end

  // Ownership state machine plus the shared register itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hold_cnt   <= '0;
      r_owner_id   <= IDW'(NUM_REQ - 1);
      r_gnt        <= '0;
      r_busy       <= 1'b0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|req) begin
            r_state    <= ST_OWN;
            r_owner_id <= w_sel_idx;
            r_gnt      <= onehot(w_sel_idx);
            r_busy     <= 1'b1;
            r_hold_cnt <= '0;
          end
        end
        ST_OWN: begin
          if (w_owner_req) begin
            r_data_out   <= w_slice[r_owner_id];
            r_data_valid <= 1'b1;
            if (w_at_limit && w_other_found) begin
              // limit reached with someone waiting: this write lands, then hand off
              r_owner_id <= w_other_idx;
              r_gnt      <= onehot(w_other_idx);
              r_hold_cnt <= '0;
            end else if (!w_at_limit) begin
              r_hold_cnt <= r_hold_cnt + 1'b1;
            end
          end else if (w_other_found) begin
            r_owner_id <= w_other_idx;
            r_gnt      <= onehot(w_other_idx);
            r_hold_cnt <= '0;
          end else begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign busy       = r_busy;
  assign owner_id   = r_owner_id;
  assign data_out   = r_data_out;
  assign data_valid = r_data_valid;

endmodule
`default_nettype wire

// File: tb/tb_register_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_register_write_arbiter
// Description : Self-checking bench for register_write_arbiter: a vector
//               table for single-writer, round-robin and isolation traffic,
//               plus hand sequences for reset, preemption and long holds.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_register_write_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        busy;
  logic [1:0]  owner_id;
  logic [7:0]  data_out;
  logic        data_valid;

  int checks   = 0;
  int failures = 0;

  register_write_arbiter #(
    .WIDTH   (8),
    .NUM_REQ (4),
    .MAX_HOLD(4)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .wdata     (wdata),
    .gnt       (gnt),
    .busy      (busy),
    .owner_id  (owner_id),
    .data_out  (data_out),
    .data_valid(data_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  e_gnt;
    logic        e_busy;
    logic [1:0]  e_owner;
    logic [7:0]  e_data;
    logic        e_valid;
  } vec_t;

  localparam int NV = 22;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] g, input logic b,
                           input logic [1:0] o, input logic [7:0] d, input logic v);
    check({tag, "_gnt"},   32'(gnt),        32'(g));
    check({tag, "_busy"},  32'(busy),       32'(b));
    check({tag, "_owner"}, 32'(owner_id),   32'(o));
    check({tag, "_data"},  32'(data_out),   32'(d));
    check({tag, "_valid"}, 32'(data_valid), 32'(v));
  endtask

  // drive at the falling edge, sample just after the next rising edge
  task automatic step(input logic r, input logic [3:0] q, input logic [31:0] w);
    @(negedge clk);
    rst_n = r;
    req   = q;
    wdata = w;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- vector table ----------------
    // single writer: grant, then 05, 0A, 03 written on successive edges
    vecs[0]  = '{1'b1, 4'b0001, 32'h00000005, 4'b0001, 1'b1, 2'd0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 4'b0001, 32'h00000005, 4'b0001, 1'b1, 2'd0, 8'h05, 1'b1};
    vecs[2]  = '{1'b1, 4'b0001, 32'h0000000A, 4'b0001, 1'b1, 2'd0, 8'h0A, 1'b1};
    vecs[3]  = '{1'b1, 4'b0001, 32'h00000003, 4'b0001, 1'b1, 2'd0, 8'h03, 1'b1};
    vecs[4]  = '{1'b1, 4'b0000, 32'h00000077, 4'b0000, 1'b0, 2'd0, 8'h03, 1'b1};
    vecs[5]  = '{1'b1, 4'b0000, 32'h00000077, 4'b0000, 1'b0, 2'd0, 8'h03, 1'b1};
    // reset so round-robin starts from owner 3
    vecs[6]  = '{1'b0, 4'b0000, 32'h00000000, 4'b0000, 1'b0, 2'd3, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 4'b0000, 32'h13121110, 4'b0000, 1'b0, 2'd3, 8'h00, 1'b0};
    // round-robin, one write each, no idle gaps
    vecs[8]  = '{1'b1, 4'b1111, 32'h13121110, 4'b0001, 1'b1, 2'd0, 8'h00, 1'b0};
    vecs[9]  = '{1'b1, 4'b1111, 32'h13121110, 4'b0001, 1'b1, 2'd0, 8'h10, 1'b1};
    vecs[10] = '{1'b1, 4'b1110, 32'h13121110, 4'b0010, 1'b1, 2'd1, 8'h10, 1'b1};
    vecs[11] = '{1'b1, 4'b1110, 32'h13121110, 4'b0010, 1'b1, 2'd1, 8'h11, 1'b1};
    vecs[12] = '{1'b1, 4'b1100, 32'h13121110, 4'b0100, 1'b1, 2'd2, 8'h11, 1'b1};
    vecs[13] = '{1'b1, 4'b1100, 32'h13121110, 4'b0100, 1'b1, 2'd2, 8'h12, 1'b1};
    vecs[14] = '{1'b1, 4'b1000, 32'h13121110, 4'b1000, 1'b1, 2'd3, 8'h12, 1'b1};
    vecs[15] = '{1'b1, 4'b1000, 32'h13121110, 4'b1000, 1'b1, 2'd3, 8'h13, 1'b1};
    vecs[16] = '{1'b1, 4'b0001, 32'h13121110, 4'b0001, 1'b1, 2'd0, 8'h13, 1'b1};
    vecs[17] = '{1'b1, 4'b0000, 32'h13121110, 4'b0000, 1'b0, 2'd0, 8'h13, 1'b1};
    // non-owner isolation: owner 1 writes AA, idle requester 3 drives 55
    vecs[18] = '{1'b1, 4'b0010, 32'h5500AA00, 4'b0010, 1'b1, 2'd1, 8'h13, 1'b1};
    vecs[19] = '{1'b1, 4'b0010, 32'h5500AA00, 4'b0010, 1'b1, 2'd1, 8'hAA, 1'b1};
    vecs[20] = '{1'b1, 4'b0010, 32'h5500AA00, 4'b0010, 1'b1, 2'd1, 8'hAA, 1'b1};
    vecs[21] = '{1'b1, 4'b0000, 32'h5500AA00, 4'b0000, 1'b0, 2'd1, 8'hAA, 1'b1};

    // ---------------- reset / idle ----------------
    rst_n = 1'b0;
    req   = 4'b0000;
    wdata = 32'h0;
    #12;
    check_all("reset", 4'b0000, 1'b0, 2'd3, 8'h00, 1'b0);
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 4'b0000, 32'hFFFFFFFF);
      check_all($sformatf("idle%0d", c), 4'b0000, 1'b0, 2'd3, 8'h00, 1'b0);
    end

    // ---------------- table ----------------
    for (int i = 0; i < NV; i++) begin
      step(vecs[i].rst_n, vecs[i].req, vecs[i].wdata);
      check_all($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_busy,
                vecs[i].e_owner, vecs[i].e_data, vecs[i].e_valid);
    end

    // ---------------- preemption: requester 2 gets exactly 4 writes ----------------
    // state: idle, last owner 1 -> search from 2
    step(1'b1, 4'b0100, 32'h00200000);
    check_all("pre_gnt", 4'b0100, 1'b1, 2'd2, 8'hAA, 1'b1);
    step(1'b1, 4'b0100, 32'h00210099);
    check_all("pre_w1", 4'b0100, 1'b1, 2'd2, 8'h21, 1'b1);
    step(1'b1, 4'b0101, 32'h00220099);
    check_all("pre_w2", 4'b0100, 1'b1, 2'd2, 8'h22, 1'b1);
    step(1'b1, 4'b0101, 32'h00230099);
    check_all("pre_w3", 4'b0100, 1'b1, 2'd2, 8'h23, 1'b1);
    step(1'b1, 4'b0101, 32'h00240099);
    check_all("pre_w4", 4'b0001, 1'b1, 2'd0, 8'h24, 1'b1);
    step(1'b1, 4'b0101, 32'h00250099);
    check_all("pre_new", 4'b0001, 1'b1, 2'd0, 8'h99, 1'b1);
    // requester 0 releases, grant returns to the waiting requester 2
    step(1'b1, 4'b0100, 32'h00300000);
    check_all("pre_back", 4'b0100, 1'b1, 2'd2, 8'h99, 1'b1);

    // ---------------- requester 2 alone for 20 cycles: no handoff ----------------
    for (int c = 0; c < 20; c++) begin
      step(1'b1, 4'b0100, {8'h00, 8'(8'h40 + c), 16'h0000});
      check($sformatf("hold%0d_gnt", c), 32'(gnt), 32'h4);
      check($sformatf("hold%0d_data", c), 32'(data_out), 32'(8'h40 + c));
    end

    // ---------------- reset mid-ownership ----------------
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all("rst_mid", 4'b0000, 1'b0, 2'd3, 8'h00, 1'b0);
    @(posedge clk);
    #1;
    check_all("rst_hold", 4'b0000, 1'b0, 2'd3, 8'h00, 1'b0);
    step(1'b1, 4'b0100, 32'h00770000);
    check_all("rst_regnt", 4'b0100, 1'b1, 2'd2, 8'h00, 1'b0);
    step(1'b1, 4'b0100, 32'h00770000);
    check_all("rst_write", 4'b0100, 1'b1, 2'd2, 8'h77, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
